// File: rtl/life_row_serializer.sv
// life_row_serializer: snapshots a WIDTHxHEIGHT life grid on request
// and streams it one row per beat with row index and live-cell count.
// Ports:
//   clk, reset (async, active-high)
//   grid        current generation, row r at grid[r*WIDTH +: WIDTH]
//   start       capture-and-send request, only honoured when idle
//   out_ready   downstream accept
//   out_valid / out_data / out_row / out_pop   beat bundle
//   busy        high while a frame is being sent
//   frame_done  one-cycle pulse after the last row is accepted
//   frame_count completed frames, wraps
module life_row_serializer #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int CNT_W  = 16,
    localparam int RW = $clog2(HEIGHT),
    localparam int PW = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*HEIGHT-1:0]   grid,
    input  logic                      start,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [RW-1:0]             out_row,
    output logic [PW-1:0]             out_pop,
    output logic                      busy,
    output logic                      frame_done,
    output logic [CNT_W-1:0]          frame_count
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state;
    logic [WIDTH*HEIGHT-1:0] snap;
    logic [RW-1:0]           row;
    logic [RW-1:0]           nxt;
    logic [WIDTH-1:0]        nxt_data;
    logic [CNT_W-1:0]        fcnt;

    function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + PW'(v[i]);
        return c;
    endfunction

    // Next row is pre-fetched so the beat bundle stays fully registered.
    always_comb begin
        nxt      = row + RW'(1);
        nxt_data = snap[nxt*WIDTH +: WIDTH];
    end

    assign out_row     = row;
    assign frame_count = fcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snap       <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_pop    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            fcnt       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap      <= grid;
                        row       <= '0;
                        out_data  <= grid[WIDTH-1:0];
                        out_pop   <= popcnt(grid[WIDTH-1:0]);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (row == RW'(HEIGHT - 1)) begin
                            out_valid  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            fcnt       <= fcnt + CNT_W'(1);
                            state      <= IDLE;
                        end else begin
                            row      <= nxt;
                            out_data <= nxt_data;
                            out_pop  <= popcnt(nxt_data);
                        end
                    end
                end
            endcase
        end
    end

endmodule
